// File: rtl/guess_pkg.sv
// Shared widths, FSM state type and the one-hot to index encoder
// used by the guessing-game input path.
package guess_pkg;

    localparam int N_SW  = 16;
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] ATT_MAX = 4'd15;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    // Returns {onehot, idx}; idx is only meaningful when onehot is set.
    function automatic logic [IDX_W:0] onehot_to_idx(input logic [N_SW-1:0] v);
        logic             is_onehot;
        logic [IDX_W-1:0] idx;
        is_onehot = (v != '0) && ((v & (v - N_SW'(1))) == '0);
        idx       = '0;
        for (int i = 0; i < N_SW; i++) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return {is_onehot, idx};
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Multi-flop synchronizer followed by a counter-based debouncer; the output
// only follows the input after DEBOUNCE_CYCLES consecutive equal samples.
module debounce_sync #(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] cand_reg;
    logic [WIDTH-1:0] stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg[gi] <= '0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= in;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign s = sync_reg[SYNC_STAGES-1];

    // Any difference from the candidate restarts the qualification window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_reg   <= '0;
            stable_reg <= '0;
            cnt_reg    <= '0;
        end else if (s != cand_reg) begin
            cand_reg <= s;
            cnt_reg  <= '0;
        end else if (cnt_reg == CNT_MAX) begin
            stable_reg <= cand_reg;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign out = stable_reg;

endmodule

// File: rtl/guess_input_encoder.sv
// Debounces switches and commit button, encodes a committed one-hot switch
// vector into a guess index and offers it over a valid/ready handshake.
module guess_input_encoder
    import guess_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  sw,
    input  logic             btn_commit,
    input  logic             clr_attempts,
    input  logic             guess_ready,
    output logic             guess_valid,
    output logic [IDX_W-1:0] guess_idx,
    output logic             guess_err,
    output logic [N_SW-1:0]  sw_stable,
    output logic [IDX_W-1:0] attempts
);

    // Cycles after reset before the debounced outputs reflect the real inputs.
    localparam int SETTLE   = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int SETTLE_W = $clog2(SETTLE + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE);

    logic [N_SW-1:0]     sw_stable_int;
    logic                btn_stable;
    logic                btn_stable_q_reg;
    logic                commit_armed_reg;
    logic [SETTLE_W-1:0] settle_cnt_reg;
    logic                settled;
    logic                commit;
    logic [IDX_W:0]      enc;

    state_t           state_reg, state_next;
    logic             valid_reg, valid_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             err_reg, err_next;
    logic [IDX_W-1:0] att_reg, att_next;

    debounce_sync #(
        .WIDTH(N_SW), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk(clk), .rst_n(rst_n), .in(sw), .out(sw_stable_int)
    );

    debounce_sync #(
        .WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk(clk), .rst_n(rst_n), .in(btn_commit), .out(btn_stable)
    );

    assign settled = (settle_cnt_reg == SETTLE_MAX);

    // Arming waits until the debouncer output is meaningful, so a button
    // held through reset never looks like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_stable_q_reg <= 1'b0;
            commit_armed_reg <= 1'b0;
            settle_cnt_reg   <= '0;
        end else begin
            btn_stable_q_reg <= btn_stable;
            if (!settled) begin
                settle_cnt_reg <= settle_cnt_reg + 1'b1;
            end else if (!btn_stable) begin
                commit_armed_reg <= 1'b1;
            end
        end
    end

    assign commit = btn_stable & ~btn_stable_q_reg & commit_armed_reg;
    assign enc    = onehot_to_idx(sw_stable_int);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            valid_reg <= 1'b0;
            idx_reg   <= '0;
            err_reg   <= 1'b0;
            att_reg   <= '0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            idx_reg   <= idx_next;
            err_reg   <= err_next;
            att_reg   <= att_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        idx_next   = idx_reg;
        err_next   = 1'b0;
        att_next   = att_reg;
        case (state_reg)
            S_IDLE: begin
                if (commit) begin
                    if (enc[IDX_W]) begin
                        idx_next   = enc[IDX_W-1:0];
                        valid_next = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (guess_ready) begin
                    valid_next = 1'b0;
                    state_next = S_IDLE;
                    if (att_reg != ATT_MAX) begin
                        att_next = att_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                valid_next = 1'b0;
            end
        endcase
        if (clr_attempts) begin
            att_next = '0;
        end
    end

    assign guess_valid = valid_reg;
    assign guess_idx   = idx_reg;
    assign guess_err   = err_reg;
    assign sw_stable   = sw_stable_int;
    assign attempts    = att_reg;

endmodule

// File: tb/tb_guess_input_encoder.sv
// Scenario bench for guess_input_encoder with a queue scoreboard of expected
// guess indices popped at each handshake transfer.
module tb_guess_input_encoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw;
    logic        btn_commit;
    logic        clr_attempts;
    logic        guess_ready;
    logic        guess_valid;
    logic [3:0]  guess_idx;
    logic        guess_err;
    logic [15:0] sw_stable;
    logic [3:0]  attempts;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_count   = 0;
    int          valid_count = 0;
    logic [3:0]  exp_q [$];
    logic [3:0]  exp_att = 4'd0;

    guess_input_encoder #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn_commit(btn_commit),
        .clr_attempts(clr_attempts), .guess_ready(guess_ready),
        .guess_valid(guess_valid), .guess_idx(guess_idx), .guess_err(guess_err),
        .sw_stable(sw_stable), .attempts(attempts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: a transfer happens at the next edge whenever valid&ready.
    always @(negedge clk) begin
        if (rst_n) begin
            if (guess_err) err_count++;
            if (guess_valid) valid_count++;
            if (guess_valid && guess_ready) begin
                logic [3:0] e;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got idx %0d, none expected", guess_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (guess_idx !== e) begin
                        n_fail++;
                        $display("FAIL transfer_idx: got %0d, expected %0d", guess_idx, e);
                    end else begin
                        $display("transfer idx=%0d ok", guess_idx);
                    end
                end
                if (!clr_attempts && exp_att != 4'd15) exp_att = exp_att + 4'd1;
            end
            if (clr_attempts) exp_att = 4'd0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_commit();
        btn_commit = 1'b1;
        tick(12);
        btn_commit = 1'b0;
        tick(12);
    endtask

    task automatic test_reset();
        int e0, v0;
        rst_n = 1'b0; sw = 16'hFFFF; btn_commit = 1'b1;
        clr_attempts = 1'b0; guess_ready = 1'b0;
        tick(3);
        @(negedge clk);
        n_checks++;
        if ({guess_valid, guess_idx, guess_err, sw_stable, attempts} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b idx=%h err=%b st=%h att=%h, expected all 0",
                     guess_valid, guess_idx, guess_err, sw_stable, attempts);
        end else $display("reset outputs all zero");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 6) begin
                n_checks++;
                if (sw_stable !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL reset_sw_early: got %h after 6 edges, expected 0000", sw_stable);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (sw_stable !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL reset_sw_latency: got %h after 7 edges, expected ffff", sw_stable);
                end else $display("sw_stable=ffff after 7 edges");
            end
        end
        e0 = err_count; v0 = valid_count;
        tick(25);
        n_checks++;
        if ((err_count - e0) != 0 || (valid_count - v0) != 0) begin
            n_fail++;
            $display("FAIL held_btn_commit: err cycles %0d valid cycles %0d, expected 0 0",
                     err_count - e0, valid_count - v0);
        end else $display("held button produced no commit");
        btn_commit = 1'b0;
        tick(12);
    endtask

    task automatic test_handshake();
        bit found = 0;
        sw = 16'h0100;
        tick(10);
        exp_q.push_back(4'd8);
        btn_commit = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (guess_valid) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL hs_valid_timeout: guess_valid=0 after 20 cycles, expected 1");
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({guess_valid, guess_idx} !== {1'b1, 4'd8}) begin
                n_fail++;
                $display("FAIL hs_hold: got v=%b idx=%0d, expected v=1 idx=8", guess_valid, guess_idx);
            end
        end
        @(posedge clk); #1;
        guess_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (guess_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_valid_drop: got %b, expected 0", guess_valid);
        end
        n_checks++;
        if (attempts !== 4'd1) begin
            n_fail++;
            $display("FAIL hs_attempts: got %0d, expected 1", attempts);
        end else $display("handshake done, attempts=1");
        @(posedge clk); #1;
        guess_ready = 1'b0;
        btn_commit = 1'b0;
        tick(12);
    endtask

    task automatic test_error(input logic [15:0] pattern);
        int e0, v0;
        sw = pattern;
        tick(10);
        e0 = err_count; v0 = valid_count;
        press_commit();
        n_checks++;
        if ((err_count - e0) != 1) begin
            n_fail++;
            $display("FAIL err_pulse_%h: got %0d err cycles, expected 1", pattern, err_count - e0);
        end else $display("err pulse one cycle for sw=%h", pattern);
        n_checks++;
        if ((valid_count - v0) != 0 || attempts !== exp_att) begin
            n_fail++;
            $display("FAIL err_side_effect_%h: valid cycles %0d att %0d, expected 0 and %0d",
                     pattern, valid_count - v0, attempts, exp_att);
        end
    endtask

    task automatic test_bounce();
        sw = 16'h0000;
        tick(10);
        for (int i = 0; i < 10; i++) begin
            sw[3] = ~sw[3];
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                n_checks++;
                if (sw_stable !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL bounce_stable: got %h during bounce, expected 0000", sw_stable);
                end
            end
            @(posedge clk); #1;
        end
        sw = 16'h0008;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 6 || k == 7) begin
                n_checks++;
                if (sw_stable !== ((k == 7) ? 16'h0008 : 16'h0000)) begin
                    n_fail++;
                    $display("FAIL bounce_latency: edge %0d got %h, expected %h", k, sw_stable,
                             (k == 7) ? 16'h0008 : 16'h0000);
                end
            end
        end
        $display("bounce settled to %h", sw_stable);
        tick(1);
    endtask

    task automatic test_busy_reset();
        int e0;
        sw = 16'h0004;
        tick(10);
        exp_q.push_back(4'd2);
        press_commit();
        sw = 16'h0002;
        tick(10);
        e0 = err_count;
        btn_commit = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c == 12) begin
                @(posedge clk); #1;
                btn_commit = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if ({guess_valid, guess_idx} !== {1'b1, 4'd2}) begin
                n_fail++;
                $display("FAIL busy_hold: got v=%b idx=%0d, expected v=1 idx=2", guess_valid, guess_idx);
            end
        end
        n_checks++;
        if (err_count != e0) begin
            n_fail++;
            $display("FAIL busy_err: got %0d err cycles, expected 0", err_count - e0);
        end else $display("busy press ignored");
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (guess_valid !== 1'b0 || attempts !== 4'd0) begin
            n_fail++;
            $display("FAIL midhold_reset: got v=%b att=%0d, expected 0 0", guess_valid, attempts);
        end else $display("reset mid-hold cleared valid and attempts");
        exp_q.delete();
        exp_att = 4'd0;
        tick(2);
        rst_n = 1'b1;
        tick(20);
    endtask

    task automatic test_sweep();
        guess_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sw = 16'h0001 << i;
            tick(10);
            exp_q.push_back(4'(i));
            press_commit();
        end
        @(negedge clk);
        n_checks++;
        if (attempts !== 4'd15 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sweep_attempts: got att=%0d pending=%0d, expected 15 0", attempts, exp_q.size());
        end else $display("sweep done, attempts=15");
        @(posedge clk); #1;
        sw = 16'h0001;
        tick(10);
        exp_q.push_back(4'd0);
        press_commit();
        @(negedge clk);
        n_checks++;
        if (attempts !== 4'd15 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL saturate: got att=%0d pending=%0d, expected 15 0", attempts, exp_q.size());
        end else $display("attempts saturated at 15");
        @(posedge clk); #1;
        clr_attempts = 1'b1;
        tick(1);
        clr_attempts = 1'b0;
        @(negedge clk);
        n_checks++;
        if (attempts !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_attempts: got %0d, expected 0", attempts);
        end else $display("clr_attempts cleared count");
        guess_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_error(16'h0000);
        test_error(16'h0101);
        test_bounce();
        test_busy_reset();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
